// File: rtl/ecc_pkg.sv
// Shared ECC definitions: default widths, log entry layout, pointer sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ecc_pkg;

    // Default widths, shared with the encoder, decoder and compare stages.
    localparam int ECC_ADDR_W = 14;
    localparam int ECC_DATA_W = 64;

    // One logged mismatch event. The field order matches the flat vector
    // {errr, addr, data} that the logger pushes into its FIFO.
    typedef struct packed {
        logic                  errr;
        logic [ECC_ADDR_W-1:0] addr;
        logic [ECC_DATA_W-1:0] data;
    } ecc_err_entry_t;

    // Pointer width for a power-of-two FIFO. The extra MSB tells full from
    // empty when the index bits are equal.
    function automatic int ecc_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ecc_log_fifo.sv
// Generic synchronous register-array FIFO; head data is read combinationally.
// Latency: a push at edge N is visible at dout_o in cycle N+1; the level updates at the same edge.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle; a pop while empty is ignored.
module ecc_log_fifo
    import ecc_pkg::*;
#(
    parameter int WIDTH = 79,
    parameter int DEPTH = 16,
    localparam int PW   = ecc_ptr_w(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PW-1:0]    level_o
);

    localparam int IW = PW - 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) &&
                     (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
    assign level_o = wr_ptr_q - rd_ptr_q;

    // A pop frees the slot the push lands in, so push-at-full with pop is legal.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Drive zero while empty so stale entries never leak out.
    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[IW-1:0]];

    // Next-state pointers; clear wins over any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers; wrap is natural modulo 2*DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset because empty masks the output.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            mem_q[wr_ptr_q[IW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/ecc_error_logger.sv
// Logs ECC compare mismatches into a FIFO with dedup, saturating counters, sticky overflow and irq.
// Latency: an event at edge N is visible on log_* in cycle N+1; irq_o lags level_o by one cycle.
// Backpressure: log drained via valid/ready; events arriving at a full FIFO with no pop are dropped and counted.
module ecc_error_logger
    import ecc_pkg::*;
#(
    parameter int ADDR_W     = ECC_ADDR_W,
    parameter int DATA_W     = ECC_DATA_W,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = 16,
    parameter int IRQ_THRESH = 8,
    parameter int DEDUP_EN   = 1,
    localparam int LVL_W     = ecc_ptr_w(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              error_flag,
    input  logic [ADDR_W-1:0] error_address,
    input  logic [DATA_W-1:0] error_data,
    input  logic              ERRr,
    input  logic              clear_i,
    output logic              log_valid_o,
    input  logic              log_ready_i,
    output logic [ADDR_W-1:0] log_addr_o,
    output logic [DATA_W-1:0] log_data_o,
    output logic              log_errr_o,
    output logic [LVL_W-1:0]  level_o,
    output logic [CNT_W-1:0]  err_cnt_o,
    output logic [CNT_W-1:0]  drop_cnt_o,
    output logic              overflow_o,
    output logic              irq_o
);

    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

    logic              hist_vld_q, hist_vld_d;
    logic [ADDR_W-1:0] hist_addr_q, hist_addr_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              ovf_q, ovf_d;
    logic              irq_q, irq_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_din;
    logic [ENTRY_W-1:0] fifo_dout;
    logic [LVL_W-1:0]   fifo_level;

    logic is_dup;
    logic do_pop;
    logic accept;
    logic do_push;
    logic do_drop;

    // Only a repeat of the last accepted address is suppressed, and only
    // while the history is valid (it is invalid after reset or clear).
    assign is_dup  = (DEDUP_EN != 0) && hist_vld_q && (error_address == hist_addr_q);
    assign do_pop  = !fifo_empty && log_ready_i && !clear_i;
    assign accept  = error_flag && !is_dup && !clear_i;
    assign do_push = accept && (!fifo_full || do_pop);
    assign do_drop = accept && fifo_full && !do_pop;

    assign fifo_din = {ERRr, error_address, error_data};

    ecc_log_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESETN),
        .push_i  (do_push),
        .pop_i   (do_pop),
        .clear_i (clear_i),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign log_valid_o = !fifo_empty;
    assign log_errr_o  = fifo_dout[ENTRY_W-1];
    assign log_addr_o  = fifo_dout[DATA_W +: ADDR_W];
    assign log_data_o  = fifo_dout[DATA_W-1:0];
    assign level_o     = fifo_level;
    assign err_cnt_o   = err_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign overflow_o  = ovf_q;
    assign irq_o       = irq_q;

    // Dedup history, saturating counters and sticky overflow; clear has priority.
    always_comb begin
        hist_vld_d  = hist_vld_q;
        hist_addr_d = hist_addr_q;
        err_cnt_d   = err_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        ovf_d       = ovf_q;
        if (clear_i) begin
            hist_vld_d = 1'b0;
            err_cnt_d  = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (accept) begin
                hist_vld_d  = 1'b1;
                hist_addr_d = error_address;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (do_drop) begin
                ovf_d = 1'b1;
                if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end
        end
    end

    // irq samples the level and overflow already visible on the outputs,
    // so it trails them by one cycle, including the fall after a clear.
    always_comb begin
        irq_d = (fifo_level >= LVL_W'(IRQ_THRESH)) || ovf_q;
    end

    // State registers for history, counters, overflow and irq.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            hist_vld_q  <= 1'b0;
            hist_addr_q <= '0;
            err_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            hist_vld_q  <= hist_vld_d;
            hist_addr_q <= hist_addr_d;
            err_cnt_q   <= err_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
        end
    end

endmodule
